// File: rtl/button_conditioner_if.sv
// Button bundle between the raw push-button pins and the game logic:
// raw levels in, debounced level and the three enable flavours out.
interface button_conditioner_if #(
    parameter int NUM_BTNS = 4
);
    logic [NUM_BTNS-1:0] buttons;
    logic [NUM_BTNS-1:0] DPBs;
    logic [NUM_BTNS-1:0] SCENs;
    logic [NUM_BTNS-1:0] MCENs;
    logic [NUM_BTNS-1:0] CCENs;

    modport master (
        output buttons,
        input  DPBs,
        input  SCENs,
        input  MCENs,
        input  CCENs
    );

    modport slave (
        input  buttons,
        output DPBs,
        output SCENs,
        output MCENs,
        output CCENs
    );
endinterface

// File: rtl/button_conditioner.sv
// Per-button synchroniser, debouncer and press/hold/auto-repeat FSM.
// Define BTN_AUTOREPEAT_EN to compile in HOLD expiry, MPULSE and REPEAT.
module button_conditioner #(
    parameter int NUM_BTNS        = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic                 clk,
    input  logic                 reset,
    button_conditioner_if.slave  btn_if
);

`ifdef BTN_AUTOREPEAT_EN
    localparam int HR_MAX  = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CNT_MAX = (DEBOUNCE_CYCLES > HR_MAX) ? DEBOUNCE_CYCLES : HR_MAX;
`else
    localparam int CNT_MAX = DEBOUNCE_CYCLES;
`endif
    localparam int CNT_W = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRESS_DB = 3'd1,
        PULSE    = 3'd2,
        HOLD     = 3'd3,
`ifdef BTN_AUTOREPEAT_EN
        MPULSE   = 3'd5,
        REPEAT   = 3'd6,
`endif
        REL_DB   = 3'd4
    } state_t;

    logic [NUM_BTNS-1:0] sync_meta_reg;
    logic [NUM_BTNS-1:0] sync_reg;
    logic [NUM_BTNS-1:0] dpb_vec;
    logic [NUM_BTNS-1:0] scen_vec;
    logic [NUM_BTNS-1:0] mcen_vec;
    logic [NUM_BTNS-1:0] ccen_vec;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_meta_reg <= '0;
            sync_reg      <= '0;
        end else begin
            sync_meta_reg <= btn_if.buttons;
            sync_reg      <= sync_meta_reg;
        end
    end

    for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_chan
        state_t           state_reg, state_next;
        logic [CNT_W-1:0] cnt_reg, cnt_next;
        logic             sync_bit;
        logic             cnt_run;

        assign sync_bit = sync_reg[gi];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_reg <= IDLE;
                cnt_reg   <= '0;
            end else begin
                state_reg <= state_next;
                cnt_reg   <= cnt_next;
            end
        end

        always_comb begin
            state_next = state_reg;
            cnt_run    = 1'b0;
            cnt_next   = '0;
            case (state_reg)
                IDLE: begin
                    if (sync_bit) state_next = PRESS_DB;
                end
                PRESS_DB: begin
                    cnt_run = 1'b1;
                    if (!sync_bit)              state_next = IDLE;
                    else if (cnt_reg == DB_LAST) state_next = PULSE;
                end
                PULSE: state_next = HOLD;
                HOLD: begin
`ifdef BTN_AUTOREPEAT_EN
                    cnt_run = 1'b1;
                    // Release is tested first so it beats a coincident expiry.
                    if (!sync_bit)                  state_next = REL_DB;
                    else if (cnt_reg == HOLD_LAST)  state_next = MPULSE;
`else
                    if (!sync_bit)                  state_next = REL_DB;
`endif
                end
`ifdef BTN_AUTOREPEAT_EN
                MPULSE: state_next = REPEAT;
                REPEAT: begin
                    cnt_run = 1'b1;
                    if (!sync_bit)                   state_next = REL_DB;
                    else if (cnt_reg == REPEAT_LAST) state_next = MPULSE;
                end
`endif
                REL_DB: begin
                    cnt_run = 1'b1;
                    // A bounce back high resumes HOLD without a fresh press pulse.
                    if (sync_bit)                state_next = HOLD;
                    else if (cnt_reg == DB_LAST) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
            // Idle-type states keep the counter parked at zero so it never wraps.
            if (cnt_run && (state_next == state_reg)) cnt_next = cnt_reg + 1'b1;
        end

        assign scen_vec[gi] = (state_reg == PULSE);
`ifdef BTN_AUTOREPEAT_EN
        assign ccen_vec[gi] = (state_reg == PULSE) || (state_reg == HOLD) ||
                              (state_reg == MPULSE) || (state_reg == REPEAT);
        assign mcen_vec[gi] = (state_reg == PULSE) || (state_reg == MPULSE);
`else
        assign ccen_vec[gi] = (state_reg == PULSE) || (state_reg == HOLD);
        assign mcen_vec[gi] = (state_reg == PULSE);
`endif
        assign dpb_vec[gi]  = ccen_vec[gi] || (state_reg == REL_DB);
    end

    assign btn_if.DPBs  = dpb_vec;
    assign btn_if.SCENs = scen_vec;
    assign btn_if.MCENs = mcen_vec;
    assign btn_if.CCENs = ccen_vec;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/hold/repeat lengths.
// Auto-repeat expectations follow BTN_AUTOREPEAT_EN as compiled.
module tb_button_conditioner;
    localparam int NB = 4;
    localparam int DB = 4;
    localparam int HC = 10;
    localparam int RC = 5;

    logic clk = 1'b0;
    logic reset;
    int   err_cnt = 0;
    int   chk_cnt = 0;

    button_conditioner_if #(.NUM_BTNS(NB)) bif ();

    button_conditioner #(
        .NUM_BTNS(NB),
        .DEBOUNCE_CYCLES(DB),
        .HOLD_CYCLES(HC),
        .REPEAT_CYCLES(RC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_if(bif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [NB-1:0] d, input logic [NB-1:0] s,
                             input logic [NB-1:0] m, input logic [NB-1:0] c);
        check({tag, ".dpb"},  bif.DPBs,  d);
        check({tag, ".scen"}, bif.SCENs, s);
        check({tag, ".mcen"}, bif.MCENs, m);
        check({tag, ".ccen"}, bif.CCENs, c);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // k = edges since the raw press was first sampled (k=1 is the first edge).
    function automatic bit mc_at(input int k);
`ifdef BTN_AUTOREPEAT_EN
        return (k == DB + 3) || ((k >= DB + 4 + HC) && (((k - (DB + 4 + HC)) % (RC + 1)) == 0));
`else
        return (k == DB + 3);
`endif
    endfunction

    initial begin
        logic [NB-1:0] v;
        reset       = 1'b0;
        bif.buttons = '0;
        #3;
        check_all("reset_noclk", '0, '0, '0, '0);
        step();
        step();
        reset = 1'b1;
        repeat (3) step();
        check_all("idle", '0, '0, '0, '0);
        $display("txn reset: checks=%0d", chk_cnt);

        // Clean press on button 0, held 60 cycles, then released.
        v = 4'b0001;
        bif.buttons = v;
        for (int k = 1; k <= 60; k++) begin
            step();
            check_all($sformatf("press0.k%0d", k), (k >= 7) ? v : '0, (k == 7) ? v : '0,
                      mc_at(k) ? v : '0, (k >= 7) ? v : '0);
        end
        bif.buttons = '0;
        for (int j = 1; j <= 12; j++) begin
            step();
            check_all($sformatf("rel0.j%0d", j), (j < 7) ? v : '0, '0, '0, (j < 3) ? v : '0);
        end
        $display("txn clean_press: checks=%0d errors=%0d", chk_cnt, err_cnt);

        // Bounce on button 2: alternate high/low for 12 cycles, then steady high.
        v = 4'b0100;
        for (int c = 0; c < 12; c++) begin
            bif.buttons = ((c % 2) == 0) ? v : '0;
            step();
            check($sformatf("bounce.dpb.c%0d", c), bif.DPBs, '0);
            check($sformatf("bounce.scen.c%0d", c), bif.SCENs, '0);
        end
        bif.buttons = v;
        for (int k = 1; k <= 20; k++) begin
            step();
            check($sformatf("steady2.scen.k%0d", k), bif.SCENs, (k == 7) ? v : '0);
            check($sformatf("steady2.dpb.k%0d", k), bif.DPBs, (k >= 7) ? v : '0);
        end
        bif.buttons = '0;
        repeat (10) step();
        check("bounce.rel.dpb", bif.DPBs, '0);
        $display("txn bounce: checks=%0d errors=%0d", chk_cnt, err_cnt);

        // Press glitch one cycle shorter than the debounce window on button 3.
        v = 4'b1000;
        for (int g = 1; g <= 15; g++) begin
            bif.buttons = (g <= DB - 1) ? v : '0;
            step();
            check($sformatf("glitch3.dpb.g%0d", g), bif.DPBs, '0);
            check($sformatf("glitch3.scen.g%0d", g), bif.SCENs, '0);
        end
        $display("txn short_glitch: checks=%0d errors=%0d", chk_cnt, err_cnt);

        // Buttons 1 and 3 rise on the same edge.
        v = 4'b1010;
        bif.buttons = v;
        for (int k = 1; k <= 40; k++) begin
            step();
            check_all($sformatf("simul.k%0d", k), (k >= 7) ? v : '0, (k == 7) ? v : '0,
                      mc_at(k) ? v : '0, (k >= 7) ? v : '0);
        end
        bif.buttons = '0;
        repeat (10) step();
        check_all("simul.rel", '0, '0, '0, '0);
        $display("txn simultaneous: checks=%0d errors=%0d", chk_cnt, err_cnt);

        // Reset asserted mid-HOLD while button 0 stays held.
        v = 4'b0001;
        bif.buttons = v;
        repeat (12) step();
        check("prereset.dpb", bif.DPBs, v);
        #2 reset = 1'b0;
        #1;
        check_all("async_reset", '0, '0, '0, '0);
        for (int r = 1; r <= 3; r++) begin
            step();
            check_all($sformatf("in_reset.r%0d", r), '0, '0, '0, '0);
        end
        reset = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            check($sformatf("postreset.scen.k%0d", k), bif.SCENs, (k == 7) ? v : '0);
            check($sformatf("postreset.dpb.k%0d", k), bif.DPBs, (k >= 7) ? v : '0);
        end
        // Two-cycle release glitch while held: level stays up, no new press pulse.
        for (int g = 1; g <= 17; g++) begin
            bif.buttons = (g <= 2) ? '0 : v;
            step();
            check($sformatf("relglitch.dpb.g%0d", g), bif.DPBs, v);
            check($sformatf("relglitch.scen.g%0d", g), bif.SCENs, '0);
        end
        bif.buttons = '0;
        repeat (10) step();
        check_all("final_idle", '0, '0, '0, '0);
        $display("txn reset_mid_hold: checks=%0d errors=%0d", chk_cnt, err_cnt);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/button_conditioner.md
# button_conditioner

Per-button input conditioning stage that sits directly upstream of the game logic. It synchronises raw push-button levels, debounces press and release, and produces four per-button outputs from a dedicated state machine and counter for each button: debounced level (DPB), single-clock enable (SCEN), multi-clock/auto-repeat enable (MCEN) and continuous enable (CCEN). Game logic consumes SCENs for one-step player moves and MCENs for held-direction repeat.

## Interface
- `NUM_BTNS`, default 4: number of independent button channels.
- `DEBOUNCE_CYCLES`, default 500000: stable cycles (5 ms at 100 MHz) required to accept a press or a release; minimum 2.
- `HOLD_CYCLES`, default 50000000: length of the HOLD state before the first auto-repeat; minimum 2.
- `REPEAT_CYCLES`, default 10000000: length of the REPEAT state between auto-repeats; minimum 2.
- `clk`  input  1  sole clock for all logic.
- `reset`  input  1  asynchronous, active-low reset.
- `buttons`  input  NUM_BTNS  raw asynchronous button levels, 1 = pressed.
- `DPBs`  output  NUM_BTNS  debounced pressed level.
- `SCENs`  output  NUM_BTNS  one-cycle pulse per accepted press.
- `MCENs`  output  NUM_BTNS  one-cycle pulses: on press, then auto-repeat while held.
- `CCENs`  output  NUM_BTNS  high every cycle while debounced-pressed, excluding release debounce.

## Operation
- Per channel: 2-FF synchroniser (`sync`), one counter sized `$clog2(max(DEBOUNCE,HOLD,REPEAT))`, and one 7-state FSM. Channels are fully independent; there is no priority or cross-coupling.
- The counter clears on every state change and otherwise increments by 1. It never wraps, because each state leaves on or before reaching its limit.
- IDLE: If `sync`=1, go to PRESS_DB.
- PRESS_DB: If `sync`=0, go to IDLE (bounce rejected). If cnt=DEBOUNCE_CYCLES-1 and `sync`=1, go to PULSE.
- PULSE: Lasts one cycle, then go to HOLD unconditionally.
- HOLD: If `sync`=0, go to REL_DB. Otherwise, if cnt=HOLD_CYCLES-1, go to MPULSE.
- MPULSE: Lasts one cycle, then go to REPEAT unconditionally.
- REPEAT: If `sync`=0, go to REL_DB. Otherwise, if cnt=REPEAT_CYCLES-1, go to MPULSE.
- REL_DB: If `sync`=1, go to HOLD with cnt cleared; this generates no new SCEN. If cnt=DEBOUNCE_CYCLES-1 and `sync`=0, go to IDLE.
- Outputs are a Moore decode of the state register:
  - DPB = state ∈ {PULSE, HOLD, MPULSE, REPEAT, REL_DB}.
  - CCEN = state ∈ {PULSE, HOLD, MPULSE, REPEAT}.
  - SCEN = (state==PULSE).
  - MCEN = state ∈ {PULSE, MPULSE}.
- Release wins over a coincident HOLD or REPEAT expiry.

## Timing
- Reset: asserting `reset` low immediately clears all FSMs to IDLE, all counters to 0 and both synchroniser stages to 0. All outputs read 0 during reset, with no clock required.
- Press latency: raw input first sampled high at edge 1 with stable input gives `sync`=1 after edge 2 and PRESS_DB after edge 3. SCEN is then high for exactly the cycle following edge DEBOUNCE_CYCLES+3.
- First auto-repeat MCEN comes HOLD_CYCLES+1 cycles after SCEN. Later MCEN pulses are spaced REPEAT_CYCLES+1 cycles apart.
- Release latency: DPB falls DEBOUNCE_CYCLES+3 cycles after a stable raw release.
- Reset released while a button is held: the channel starts from IDLE and a fresh SCEN follows after full debounce. Exactly one SCEN is produced.
- Glitches shorter than DEBOUNCE_CYCLES in either direction never change DPB and never create extra SCENs.

## Configuration
- `BTN_AUTOREPEAT_EN` defined:
  - HOLD expiry, MPULSE and REPEAT are compiled in.
  - MCEN repeats as described above.
- `BTN_AUTOREPEAT_EN` not defined:
  - MPULSE and REPEAT are removed, and HOLD never expires (exits only to REL_DB).
  - MCENs is identical to SCENs.
  - The counter is sized from DEBOUNCE_CYCLES only.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=5.
- Clean press, button 0: raw high at edge 1, held 60 cycles.
  - SCENs[0] is a single pulse in the cycle after edge 7.
  - DPBs[0] is high from edge 7 until 7 cycles after raw falls.
- Bounce, button 2: 1-high/1-low pattern for 12 cycles, then steady high.
  - Exactly one SCENs[2] pulse, 7 edges after steady high begins.
  - No DPB activity during the bounce.
- Auto-repeat, `BTN_AUTOREPEAT_EN` on: 40-cycle hold of button 1 with SCEN at cycle t.
  - MCENs[1] pulses at t, t+11, t+17, t+23, t+29…
  - CCENs[1] is high continuously from t.
- Simultaneous: buttons 1 and 3 rise on the same edge.
  - SCENs[1] and SCENs[3] pulse in the same cycle.
  - Other channels stay 0.
- Reset mid-HOLD: drive `reset` low for 3 cycles while button 0 stays held.
  - All outputs go 0 asynchronously.
  - After `reset` deasserts, exactly one new SCENs[0], DEBOUNCE_CYCLES+3 edges later.
- Auto-repeat off, `BTN_AUTOREPEAT_EN` undefined: 40-cycle hold.
  - Single MCENs pulse, coincident with SCENs.
  - No further MCENs pulses.
